// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage
//   MEM/WB pipeline register for the pipelined RISC-V core. Selects one of four
//   write-back sources, extracts and extends load bytes/halfwords/words, flags
//   misaligned or illegal loads, and drives the register-file write port. It
//   also exposes forwarding data and keeps retire/load-error counters.
//
// Parameters
//   XLEN      datapath width (32 or 64)
//   RADDR_W   register address width
//   ERRCNT_W  width of the saturating load-error counter
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid          MEM-stage instruction presented
//   in_ready          stage accepts this cycle (= !stall)
//   stall, flush      hold / kill the instruction being accepted
//   RUDataWrSrc       00 ALURes, 01 load, 10 PC_with_offset, 11 Imm
//   ALURes            ALU result; low 2 bits are the load byte offset
//   DataRd            raw aligned memory word
//   PC_with_offset    PC+4 for jal/jalr
//   Imm               immediate for lui
//   LoadFunct3        load type (LB/LH/LW/LBU/LHU)
//   Rd, RUWr          destination register and its write enable
//   rf_we/waddr/wdata register-file write port
//   fwd_valid         qualifies rf_waddr/rf_wdata for forwarding
//   load_err          one-cycle pulse for a misaligned/illegal load
//   err_count         saturating count of load_err pulses
//   retired           wrapping count of instructions leaving the stage
// -----------------------------------------------------------------------------
module wb_stage #(
    parameter int XLEN     = 32,
    parameter int RADDR_W  = 5,
    parameter int ERRCNT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                stall,
    input  logic                flush,
    input  logic [1:0]          RUDataWrSrc,
    input  logic [XLEN-1:0]     ALURes,
    input  logic [XLEN-1:0]     DataRd,
    input  logic [XLEN-1:0]     PC_with_offset,
    input  logic [XLEN-1:0]     Imm,
    input  logic [2:0]          LoadFunct3,
    input  logic [RADDR_W-1:0]  Rd,
    input  logic                RUWr,
    output logic                rf_we,
    output logic [RADDR_W-1:0]  rf_waddr,
    output logic [XLEN-1:0]     rf_wdata,
    output logic                fwd_valid,
    output logic                load_err,
    output logic [ERRCNT_W-1:0] err_count,
    output logic [31:0]         retired
);

    localparam logic [1:0] SRC_ALU  = 2'b00;
    localparam logic [1:0] SRC_LOAD = 2'b01;
    localparam logic [1:0] SRC_PC   = 2'b10;
    localparam logic [1:0] SRC_IMM  = 2'b11;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Sign or zero extension of load fragments to the datapath width.
    function automatic logic [XLEN-1:0] ext8(input logic [7:0] v, input logic sgn);
        logic signed [7:0] s;
        logic [XLEN-1:0]   r;
        s = v;
        if (sgn) r = XLEN'(s);
        else     r = XLEN'(v);
        return r;
    endfunction

    function automatic logic [XLEN-1:0] ext16(input logic [15:0] v, input logic sgn);
        logic signed [15:0] s;
        logic [XLEN-1:0]    r;
        s = v;
        if (sgn) r = XLEN'(s);
        else     r = XLEN'(v);
        return r;
    endfunction

    function automatic logic [XLEN-1:0] ext32(input logic [31:0] v);
        logic signed [31:0] s;
        s = v;
        return XLEN'(s);
    endfunction

    // Counter increment that sticks at all-ones.
    function automatic logic [ERRCNT_W-1:0] sat_inc(input logic [ERRCNT_W-1:0] v);
        logic [ERRCNT_W-1:0] r;
        if (&v) r = v;
        else    r = v + ERRCNT_W'(1);
        return r;
    endfunction

    logic                accept_p0;
    logic [1:0]          off_p0;
    logic [7:0]          byte_p0;
    logic [15:0]         half_p0;
    logic [XLEN-1:0]     ld_data_p0;
    logic                ld_err_p0;
    logic [XLEN-1:0]     sel_data_p0;
    logic                sel_err_p0;

    logic                vld_p1;
    logic [RADDR_W-1:0]  rd_p1;
    logic                ruwr_p1;
    logic                err_p1;
    logic [XLEN-1:0]     data_p1;

    assign in_ready  = !stall;
    // flush outranks in_valid; stall blocks only the accept.
    assign accept_p0 = in_valid && !stall && !flush;

    // ---- p0: source select and load extraction (combinational, MEM side) ----
    always_comb begin
        off_p0     = ALURes[1:0];
        byte_p0    = DataRd[{off_p0, 3'b000} +: 8];
        half_p0    = DataRd[{off_p0[1], 4'b0000} +: 16];
        ld_data_p0 = '0;
        ld_err_p0  = 1'b0;
        case (LoadFunct3)
            F3_LB:  ld_data_p0 = ext8(byte_p0, 1'b1);
            F3_LBU: ld_data_p0 = ext8(byte_p0, 1'b0);
            F3_LH: begin
                ld_data_p0 = ext16(half_p0, 1'b1);
                ld_err_p0  = off_p0[0];
            end
            F3_LHU: begin
                ld_data_p0 = ext16(half_p0, 1'b0);
                ld_err_p0  = off_p0[0];
            end
            F3_LW: begin
                ld_data_p0 = ext32(DataRd[31:0]);
                ld_err_p0  = (off_p0 != 2'b00);
            end
            default: ld_err_p0 = 1'b1;
        endcase

        sel_data_p0 = '0;
        sel_err_p0  = 1'b0;
        case (RUDataWrSrc)
            SRC_ALU:  sel_data_p0 = ALURes;
            SRC_LOAD: begin
                // A faulting load captures zero so nothing stale can forward.
                sel_err_p0  = ld_err_p0;
                sel_data_p0 = ld_err_p0 ? '0 : ld_data_p0;
            end
            SRC_PC:   sel_data_p0 = PC_with_offset;
            SRC_IMM:  sel_data_p0 = Imm;
            default:  sel_data_p0 = '0;
        endcase
    end

    // ---- p1: MEM/WB register ----
    // Payload loads only on accept so rf_waddr/rf_wdata hold the last capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            rd_p1   <= '0;
            ruwr_p1 <= 1'b0;
            err_p1  <= 1'b0;
            data_p1 <= '0;
        end else begin
            vld_p1 <= accept_p0;
            if (accept_p0) begin
                rd_p1   <= Rd;
                ruwr_p1 <= RUWr;
                err_p1  <= sel_err_p0;
                data_p1 <= sel_data_p0;
            end
        end
    end

    assign rf_we     = vld_p1 && ruwr_p1 && (rd_p1 != '0) && !err_p1;
    assign fwd_valid = rf_we;
    assign rf_waddr  = rd_p1;
    assign rf_wdata  = data_p1;
    assign load_err  = vld_p1 && err_p1;

    // ---- p2: commit counters, updated on the edge that retires the p1 entry ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired   <= '0;
            err_count <= '0;
        end else begin
            retired <= retired + {31'b0, vld_p1};
            if (load_err) begin
                err_count <= sat_inc(err_count);
            end
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

    localparam int XLEN     = 32;
    localparam int RADDR_W  = 5;
    localparam int ERRCNT_W = 8;
    localparam logic [31:0] D = 32'h80FF7F01;
    localparam int NV = 22;

    logic                clk;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic                stall;
    logic                flush;
    logic [1:0]          RUDataWrSrc;
    logic [XLEN-1:0]     ALURes;
    logic [XLEN-1:0]     DataRd;
    logic [XLEN-1:0]     PC_with_offset;
    logic [XLEN-1:0]     Imm;
    logic [2:0]          LoadFunct3;
    logic [RADDR_W-1:0]  Rd;
    logic                RUWr;
    logic                rf_we;
    logic [RADDR_W-1:0]  rf_waddr;
    logic [XLEN-1:0]     rf_wdata;
    logic                fwd_valid;
    logic                load_err;
    logic [ERRCNT_W-1:0] err_count;
    logic [31:0]         retired;

    wb_stage #(.XLEN(XLEN), .RADDR_W(RADDR_W), .ERRCNT_W(ERRCNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .stall(stall), .flush(flush), .RUDataWrSrc(RUDataWrSrc), .ALURes(ALURes),
        .DataRd(DataRd), .PC_with_offset(PC_with_offset), .Imm(Imm),
        .LoadFunct3(LoadFunct3), .Rd(Rd), .RUWr(RUWr), .rf_we(rf_we),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .fwd_valid(fwd_valid),
        .load_err(load_err), .err_count(err_count), .retired(retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  src;
        logic [31:0] alu;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic        ruwr;
        logic        exp_we;
        logic        exp_err;
        logic [31:0] exp_data;
    } vec_t;

    typedef struct {
        logic        we;
        logic        err;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } exp_t;

    vec_t tbl [NV];
    exp_t sbq [$];
    int   checks   = 0;
    int   failures = 0;
    int   ret_m    = 0;
    int   err_m    = 0;

    function automatic vec_t mkv(input logic [1:0] src, input logic [31:0] alu,
                                 input logic [31:0] pc, input logic [31:0] imm,
                                 input logic [2:0] f3, input logic [4:0] rd,
                                 input logic ruwr, input logic we, input logic err,
                                 input logic [31:0] data);
        vec_t v;
        v.src = src; v.alu = alu; v.pc = pc; v.imm = imm; v.f3 = f3; v.rd = rd;
        v.ruwr = ruwr; v.exp_we = we; v.exp_err = err; v.exp_data = data;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v, input logic iv, input logic st, input logic fl);
        exp_t e;
        in_valid       = iv;
        stall          = st;
        flush          = fl;
        RUDataWrSrc    = v.src;
        ALURes         = v.alu;
        DataRd         = D;
        PC_with_offset = v.pc;
        Imm            = v.imm;
        LoadFunct3     = v.f3;
        Rd             = v.rd;
        RUWr           = v.ruwr;
        if (rst_n && iv && !st && !fl) begin
            e.we = v.exp_we; e.err = v.exp_err; e.waddr = v.rd; e.wdata = v.exp_data;
            sbq.push_back(e);
        end
    endtask

    // One clock; then compare counters against the model and pop the expected
    // presentation (if any) for this cycle.
    task automatic step(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        chk({tag, "_retired"}, 64'(retired), 64'(ret_m));
        chk({tag, "_errcnt"}, 64'(err_count), 64'(err_m));
        chk({tag, "_in_ready"}, 64'(in_ready), 64'(!stall));
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk({tag, "_we"}, 64'(rf_we), 64'(e.we));
            chk({tag, "_fwd"}, 64'(fwd_valid), 64'(e.we));
            chk({tag, "_lerr"}, 64'(load_err), 64'(e.err));
            chk({tag, "_waddr"}, 64'(rf_waddr), 64'(e.waddr));
            chk({tag, "_wdata"}, 64'(rf_wdata), 64'(e.wdata));
            ret_m++;
            if (e.err && err_m != 255) err_m++;
        end else begin
            chk({tag, "_idle_we"}, 64'(rf_we), 64'd0);
            chk({tag, "_idle_fwd"}, 64'(fwd_valid), 64'd0);
            chk({tag, "_idle_lerr"}, 64'(load_err), 64'd0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_we"}, 64'(rf_we), 64'd0);
        chk({tag, "_fwd"}, 64'(fwd_valid), 64'd0);
        chk({tag, "_lerr"}, 64'(load_err), 64'd0);
        chk({tag, "_waddr"}, 64'(rf_waddr), 64'd0);
        chk({tag, "_wdata"}, 64'(rf_wdata), 64'd0);
        chk({tag, "_errcnt"}, 64'(err_count), 64'd0);
        chk({tag, "_retired"}, 64'(retired), 64'd0);
    endtask

    initial begin
        vec_t idle, va, vb, vf, vg;
        //               src    alu            pc            imm           f3      rd   ruwr we   err  data
        tbl[0]  = mkv(2'b00, 32'h11,       32'hC0000000, 32'hB0000000, 3'b000, 5,  1, 1, 0, 32'h11);
        tbl[1]  = mkv(2'b11, 32'hAAAA,     32'hC0000000, 32'h12345000, 3'b000, 6,  1, 1, 0, 32'h12345000);
        tbl[2]  = mkv(2'b10, 32'hAAAA,     32'h104,      32'hB0000000, 3'b000, 7,  1, 1, 0, 32'h104);
        tbl[3]  = mkv(2'b01, 32'h3,        32'hC0000000, 32'hB0000000, 3'b000, 8,  1, 1, 0, 32'hFFFFFF80);
        tbl[4]  = mkv(2'b01, 32'h1,        32'hC0000000, 32'hB0000000, 3'b100, 9,  1, 1, 0, 32'h0000007F);
        tbl[5]  = mkv(2'b01, 32'h2,        32'hC0000000, 32'hB0000000, 3'b001, 10, 1, 1, 0, 32'hFFFF80FF);
        tbl[6]  = mkv(2'b01, 32'h0,        32'hC0000000, 32'hB0000000, 3'b101, 11, 1, 1, 0, 32'h00007F01);
        tbl[7]  = mkv(2'b01, 32'h1000,     32'hC0000000, 32'hB0000000, 3'b010, 12, 1, 1, 0, 32'h80FF7F01);
        tbl[8]  = mkv(2'b01, 32'h0,        32'hC0000000, 32'hB0000000, 3'b000, 13, 1, 1, 0, 32'h00000001);
        tbl[9]  = mkv(2'b01, 32'h2,        32'hC0000000, 32'hB0000000, 3'b100, 14, 1, 1, 0, 32'h000000FF);
        tbl[10] = mkv(2'b01, 32'h2,        32'hC0000000, 32'hB0000000, 3'b101, 15, 1, 1, 0, 32'h000080FF);
        tbl[11] = mkv(2'b01, 32'h0,        32'hC0000000, 32'hB0000000, 3'b001, 16, 1, 1, 0, 32'h00007F01);
        tbl[12] = mkv(2'b01, 32'h2,        32'hC0000000, 32'hB0000000, 3'b010, 17, 1, 0, 1, 32'h0);
        tbl[13] = mkv(2'b01, 32'h0,        32'hC0000000, 32'hB0000000, 3'b110, 18, 1, 0, 1, 32'h0);
        tbl[14] = mkv(2'b01, 32'h1,        32'hC0000000, 32'hB0000000, 3'b001, 19, 1, 0, 1, 32'h0);
        tbl[15] = mkv(2'b01, 32'h0,        32'hC0000000, 32'hB0000000, 3'b011, 20, 1, 0, 1, 32'h0);
        tbl[16] = mkv(2'b00, 32'hDEAD,     32'hC0000000, 32'hB0000000, 3'b000, 0,  1, 0, 0, 32'hDEAD);
        tbl[17] = mkv(2'b00, 32'h55,       32'hC0000000, 32'hB0000000, 3'b000, 3,  0, 0, 0, 32'h55);
        tbl[18] = mkv(2'b00, 32'h123,      32'hC0000000, 32'hB0000000, 3'b111, 21, 1, 1, 0, 32'h123);
        tbl[19] = mkv(2'b10, 32'h1,        32'h200,      32'hB0000000, 3'b010, 22, 1, 1, 0, 32'h200);
        tbl[20] = mkv(2'b01, 32'h0,        32'hC0000000, 32'hB0000000, 3'b111, 23, 1, 0, 1, 32'h0);
        tbl[21] = mkv(2'b01, 32'h3,        32'hC0000000, 32'hB0000000, 3'b100, 24, 1, 1, 0, 32'h00000080);

        idle = mkv(2'b00, 32'h0, 32'h0, 32'h0, 3'b000, 0, 0, 0, 0, 32'h0);
        va   = mkv(2'b00, 32'hA1, 32'h0, 32'h0, 3'b000, 9,  1, 1, 0, 32'hA1);
        vb   = mkv(2'b11, 32'h0,  32'h0, 32'hB2, 3'b000, 10, 1, 1, 0, 32'hB2);
        vf   = mkv(2'b00, 32'hF1, 32'h0, 32'h0, 3'b000, 11, 1, 1, 0, 32'hF1);
        vg   = mkv(2'b10, 32'h0,  32'h6C, 32'h0, 3'b000, 12, 1, 1, 0, 32'h6C);

        // Power-on reset, with a request pending that must be ignored.
        rst_n = 1'b0;
        drive(va, 1'b1, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("por");

        // Release between edges; first accept happens on the very next edge.
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NV; i++) begin
            drive(tbl[i], 1'b1, 1'b0, 1'b0);
            step($sformatf("vec%0d", i));
        end
        drive(idle, 1'b0, 1'b0, 1'b0);
        step("drain");
        chk("table_retired", 64'(retired), 64'(NV));
        chk("table_errcnt", 64'(err_count), 64'd5);

        // Stall for 3 cycles with in_valid held: prior instruction commits once.
        drive(va, 1'b1, 1'b0, 1'b0);
        step("pre_stall");
        for (int i = 0; i < 3; i++) begin
            drive(vb, 1'b1, 1'b1, 1'b0);
            step($sformatf("stall%0d", i));
        end
        drive(vb, 1'b1, 1'b0, 1'b0);
        step("after_stall");

        // Flush kills the accept.
        drive(va, 1'b1, 1'b0, 1'b1);
        step("flush");

        // stall+flush: no accept, but the registered instruction still commits.
        drive(vf, 1'b1, 1'b0, 1'b0);
        step("pre_sf");
        drive(va, 1'b1, 1'b1, 1'b1);
        step("stall_flush");
        drive(idle, 1'b0, 1'b0, 1'b0);
        step("post_sf");

        // 300 misaligned loads drive the error counter into saturation.
        for (int i = 0; i < 300; i++) begin
            drive(tbl[12], 1'b1, 1'b0, 1'b0);
            step("sat");
        end
        drive(idle, 1'b0, 1'b0, 1'b0);
        step("sat_drain");
        chk("sat_errcnt", 64'(err_count), 64'd255);

        // Asynchronous reset between edges while an instruction is presented.
        drive(vf, 1'b1, 1'b0, 1'b0);
        step("pre_arst");
        chk("pre_arst_valid", 64'(rf_we), 64'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("arst");
        sbq.delete();
        ret_m = 0;
        err_m = 0;
        drive(vg, 1'b1, 1'b0, 1'b0);
        step("arst_hold");
        @(negedge clk);
        rst_n = 1'b1;
        drive(idle, 1'b0, 1'b0, 1'b0);
        step("arst_idle");
        chk("arst_retired_zero", 64'(retired), 64'd0);
        drive(vg, 1'b1, 1'b0, 1'b0);
        step("arst_new");
        drive(idle, 1'b0, 1'b0, 1'b0);
        step("arst_new_drain");
        chk("arst_retired_one", 64'(retired), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
# wb_stage

Registered write-back stage for the pipelined successor of the single-cycle RISC-V core. It replaces the combinational write-back data mux with a parametrised MEM/WB pipeline register. The stage has four write-data sources, load byte/halfword extraction with sign or zero extension, and misaligned/illegal load detection. It drives the register-file write port and exposes forwarding data and retire/error counters.

## Interface
- XLEN, 32: datapath width; legal values are 32 and 64.
- RADDR_W, 5: register address width.
- ERRCNT_W, 8: width of the saturating load-error counter.

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  a MEM-stage instruction is presented.
- in_ready  out  1  the stage accepts this cycle; equals !stall.
- stall  in  1  hazard unit holds MEM; no accept this cycle.
- flush  in  1  kills the instruction being accepted this cycle.
- RUDataWrSrc  in  2  write-data source: 00 ALURes, 01 load data, 10 PC_with_offset, 11 Imm.
- ALURes  in  XLEN  ALU result; its low 2 bits are also the load byte offset.
- DataRd  in  XLEN  raw aligned memory word.
- PC_with_offset  in  XLEN  PC+4 for jal/jalr.
- Imm  in  XLEN  immediate for lui.
- LoadFunct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; all other codes are illegal.
- Rd  in  RADDR_W  destination register.
- RUWr  in  1  the instruction writes the register file.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  RADDR_W  register-file write address.
- rf_wdata  out  XLEN  register-file write data.
- fwd_valid  out  1  equals rf_we; qualifies forwarding of rf_waddr/rf_wdata.
- load_err  out  1  one-cycle pulse for a misaligned or illegal load.
- err_count  out  ERRCNT_W  saturating count of load_err pulses.
- retired  out  32  count of instructions retired by the stage, wrapping.

## Operation
- Accept condition: in_valid && !stall && !flush.
- On accept, capture wb_valid=1 together with Rd, RUWr, and the selected data.
- Without an accept, wb_valid clears to 0 at the next edge. Each accepted instruction is therefore presented for exactly one cycle.
- stall blocks the accept only. An instruction already in the register still commits.
- flush has priority over in_valid. It never affects the instruction already registered.
- Load extraction uses off = ALURes[1:0]:
  - LB/LBU: byte DataRd[8*off+7 : 8*off].
  - LH/LHU: halfword DataRd[16*off[1]+15 : 16*off[1]].
  - LW: DataRd[31:0].
  - LB, LH and (for XLEN=64) LW sign-extend to XLEN. LBU and LHU zero-extend.
- Error cases when RUDataWrSrc=01:
  - Misaligned: LH/LHU with off[0]=1, or LW with off≠00.
  - Illegal: LoadFunct3 in {011, 110, 111}.
  - Either case sets the registered error flag. The write is suppressed and the data is captured as 0.
- Error checks are ignored when RUDataWrSrc≠01.
- Outputs:
  - rf_we = wb_valid && wb_RUWr && (wb_rd≠0) && !wb_err.
  - rf_wdata and rf_waddr come from the register. Their value is don't-care when rf_we=0, but they hold the last captured value.
  - load_err = wb_valid && wb_err.
- Counters:
  - retired increments by 1 each cycle wb_valid=1, including error and x0 cases, and wraps 0xFFFFFFFF→0.
  - err_count increments on load_err and saturates at all-ones.

## Timing
- Latency is 1 cycle: inputs accepted at edge N appear on rf_* and load_err during cycle N+1. The register file writes at edge N+1.
- Throughput is one instruction per cycle with no bubbles when stall=0.
- Reset (rst_n=0, asynchronous) forces: wb_valid=0, rf_we=0, fwd_valid=0, load_err=0, rf_waddr=0, rf_wdata=0, err_count=0, retired=0.
- A reset asserted mid-operation drops the in-flight instruction: no write and no count.
- The first accept is possible on the first rising edge after rst_n deasserts.
- in_ready is combinational from stall. It does not depend on in_valid.
- When stall and flush are asserted together, no accept occurs and the registered instruction still commits.
- err_count and retired update on the same edge that clears or reloads wb_valid. Both counters reflect the committed instruction one cycle after it appears on the outputs.

## Test plan
- Back-to-back sources: ALURes=0x11, then Imm=0x12345000, then PC_with_offset=0x104, each with Rd=5/6/7. Required: rf_we high for 3 consecutive cycles with the matching data; retired=3.
- Load extraction with DataRd=0x80FF7F01:
  - LB at off=3 → 0xFFFFFF80.
  - LBU at off=1 → 0x0000007F.
  - LH at off=2 → 0xFFFF80FF.
  - LHU at off=0 → 0x00007F01.
  - LW → 0x80FF7F01.
- Errors: LW with off=2, then LoadFunct3=110. Required: 2 load_err pulses, rf_we=0 both cycles, err_count=2. Then 300 misaligned loads with ERRCNT_W=8. Required: err_count saturates at 255.
- x0 and RUWr=0: Rd=0 with ALURes=0xDEAD, then Rd=3 with RUWr=0. Required: rf_we=0 both cycles; retired still increments by 2.
- Stall/flush:
  - stall for 3 cycles with in_valid=1. Required: exactly one commit of the prior instruction, then no rf_we.
  - flush with in_valid=1. Required: no commit the next cycle.
  - stall+flush together. Required: the registered instruction commits.
- Async reset mid-stream: drop rst_n between edges while wb_valid=1. Required: all outputs 0 immediately; the counters stay 0 until a new accept.
